// File: rtl/tnn_group_scheduler.sv
// rtl/tnn_group_scheduler.sv - time-multiplexes a shared 4-input TNN core over N_GROUPS feature windows
//
// Purpose: accepts one sample per in_valid/in_ready handshake, presents one
// 4-feature window (one byte) per cycle to an external combinational core,
// collects the 1-bit results and reports them with a popcount and a majority
// vote on an out_valid/out_ready port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        sample handshake; in_data holds N_GROUPS bytes
//   core_a..core_d, core_out operands to / result from the shared core
//   out_valid/out_ready      result handshake
//   out_bits, out_count      per-group results and their popcount
//   out_vote                 1 iff 2*out_count > N_GROUPS
//   busy                     state is not IDLE
module tnn_group_scheduler #(
    parameter int N_GROUPS = 4,
    localparam int CW = $clog2(N_GROUPS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*N_GROUPS-1:0] in_data,
    output logic [1:0]            core_a,
    output logic [1:0]            core_b,
    output logic [1:0]            core_c,
    output logic [1:0]            core_d,
    input  logic                  core_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_GROUPS-1:0]   out_bits,
    output logic [CW-1:0]         out_count,
    output logic                  out_vote,
    output logic                  busy
);

    localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(N_GROUPS - 1);
    // Majority threshold compared against 2*count, one extra bit of headroom.
    localparam logic [CW+1:0] N_CMP = (CW + 2)'(N_GROUPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           g_q, g_d;
    logic [8*N_GROUPS-1:0]   sample_q, sample_d;
    logic [N_GROUPS-1:0]     bits_q, bits_d;
    logic [CW-1:0]           count_q, count_d;
    logic [7:0]              cur_byte;

    // Byte g of the latched sample; only meaningful while in RUN.
    assign cur_byte = 8'(sample_q >> {g_q, 3'b000});

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        sample_d = sample_q;
        bits_d   = bits_q;
        count_d  = count_q;
        in_ready = 1'b0;
        out_valid = 1'b0;
        core_a   = 2'd0;
        core_b   = 2'd0;
        core_c   = 2'd0;
        core_d   = 2'd0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sample_d = in_data;
                    bits_d   = '0;
                    count_d  = '0;
                    g_d      = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                core_a = cur_byte[1:0];
                core_b = cur_byte[3:2];
                core_c = cur_byte[5:4];
                core_d = cur_byte[7:6];
                bits_d[g_q] = core_out;
                count_d     = count_q + CW'(core_out);
                if (g_q == G_LAST) begin
                    state_d = S_DONE;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            g_q      <= '0;
            sample_q <= '0;
            bits_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            sample_q <= sample_d;
            bits_q   <= bits_d;
            count_q  <= count_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_bits  = bits_q;
    assign out_count = count_q;
    assign out_vote  = ({1'b0, count_q, 1'b0} > N_CMP);

endmodule

// File: tb/tb_tnn_group_scheduler.sv
// tb/tb_tnn_group_scheduler.sv - scoreboard bench for tnn_group_scheduler (N_GROUPS=4 and N_GROUPS=1)
module tb_tnn_group_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N_GROUPS = 4 instance
    logic        in_valid4, in_ready4, core_out4, out_valid4, out_ready4, out_vote4, busy4;
    logic [31:0] in_data4;
    logic [1:0]  core_a4, core_b4, core_c4, core_d4;
    logic [3:0]  out_bits4;
    logic [2:0]  out_count4;

    // N_GROUPS = 1 instance
    logic        in_valid1, in_ready1, core_out1, out_valid1, out_ready1, out_vote1, busy1;
    logic [7:0]  in_data1;
    logic [1:0]  core_a1, core_b1, core_c1, core_d1;
    logic [0:0]  out_bits1;
    logic [0:0]  out_count1;

    assign core_out4 = core_a4[1];
    assign core_out1 = core_a1[1];

    tnn_group_scheduler #(.N_GROUPS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .core_a(core_a4), .core_b(core_b4), .core_c(core_c4), .core_d(core_d4),
        .core_out(core_out4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_bits(out_bits4), .out_count(out_count4), .out_vote(out_vote4),
        .busy(busy4)
    );

    tnn_group_scheduler #(.N_GROUPS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .core_a(core_a1), .core_b(core_b1), .core_c(core_c1), .core_d(core_d1),
        .core_out(core_out1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_bits(out_bits1), .out_count(out_count1), .out_vote(out_vote1),
        .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] bits;
        int          cnt;
        logic        vote;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    // Reference: group g fires iff bit 1 of its byte is set (core = core_a[1]);
    // vote is a strict majority over n groups.
    function automatic exp_t model(input logic [127:0] d, input int n);
        exp_t e;
        e.bits = '0;
        e.cnt  = 0;
        for (int g = 0; g < n; g++) begin
            e.bits[g] = d[8*g+1];
            e.cnt += int'(d[8*g+1]);
        end
        e.vote = (2 * e.cnt > n);
        return e;
    endfunction

    // Monitor for the N=4 instance: compare on first valid cycle, then check hold.
    bit         seen4 = 0;
    exp_t       cur4;
    logic [3:0] hb4;
    logic [2:0] hc4;
    logic       hv4;
    always @(negedge clk) begin
        if (rst) begin
            seen4 = 0;
        end else if (out_valid4) begin
            if (!seen4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_valid4", 32'd1, 32'd0);
                end else begin
                    cur4 = q4.pop_front();
                    chk("bits4", out_bits4, cur4.bits[3:0]);
                    chk("count4", out_count4, cur4.cnt);
                    chk("vote4", out_vote4, cur4.vote);
                end
                hb4 = out_bits4; hc4 = out_count4; hv4 = out_vote4;
                seen4 = 1;
            end else begin
                chk("hold_bits4", out_bits4, hb4);
                chk("hold_count4", out_count4, hc4);
                chk("hold_vote4", out_vote4, hv4);
            end
            if (out_ready4) seen4 = 0;
        end
    end

    // Monitor for the N=1 instance (out_ready1 is always 1).
    exp_t cur1;
    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                chk("unexpected_valid1", 32'd1, 32'd0);
            end else begin
                cur1 = q1.pop_front();
                chk("bits1", out_bits1, cur1.bits[0]);
                chk("count1", out_count1, cur1.cnt);
                chk("vote1", out_vote1, cur1.vote);
            end
        end
    end

    // Random backpressure on the N=4 output port.
    bit rand_rdy = 0;
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready4 = 1'($urandom_range(0, 1));
    end

    task automatic accept4(input logic [31:0] d, input bit push);
        int t;
        @(posedge clk); #1;
        in_valid4 = 1'b1;
        in_data4  = d;
        if (push) q4.push_back(model(128'(d), 4));
        t = 0;
        @(negedge clk);
        while (!in_ready4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept4_ready", in_ready4, 1'b1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d, input bit push);
        logic [7:0] b;
        accept4(d, push);
        for (int g = 0; g < 4; g++) begin
            b = d[8*g +: 8];
            @(negedge clk);
            chk("core_a4", core_a4, b[1:0]);
            chk("core_b4", core_b4, b[3:2]);
            chk("core_c4", core_c4, b[5:4]);
            chk("core_d4", core_d4, b[7:6]);
            chk("run_valid4", out_valid4, 1'b0);
            chk("run_ready4", in_ready4, 1'b0);
        end
        @(negedge clk);
        chk("latency_valid4", out_valid4, 1'b1);
    endtask

    task automatic send1(input logic [7:0] d);
        int t;
        @(posedge clk); #1;
        in_valid1 = 1'b1;
        in_data1  = d;
        q1.push_back(model(128'(d), 1));
        t = 0;
        @(negedge clk);
        while (!in_ready1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept1_ready", in_ready1, 1'b1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("core_a1", core_a1, d[1:0]);
        chk("run_valid1", out_valid1, 1'b0);
        @(negedge clk);
        chk("latency_valid1", out_valid1, 1'b1);
    endtask

    task automatic drain4();
        int t = 0;
        while ((q4.size() != 0 || out_valid4) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain4", q4.size(), 0);
    endtask

    task automatic drain1();
        int t = 0;
        while ((q1.size() != 0 || out_valid1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain1", q1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs
        in_valid4 = 1'b1; in_data4 = $urandom; out_ready4 = 1'($urandom_range(0, 1));
        in_valid1 = 1'b1; in_data1 = 8'($urandom); out_ready1 = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_data4 = $urandom; in_data1 = 8'($urandom); out_ready4 = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready4", in_ready4, 1'b1);
        chk("rst_out_valid4", out_valid4, 1'b0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_bits4", out_bits4, 4'd0);
        chk("rst_count4", out_count4, 3'd0);
        chk("rst_vote4", out_vote4, 1'b0);
        chk("rst_core4", {core_a4, core_b4, core_c4, core_d4}, 8'd0);
        chk("rst_in_ready1", in_ready1, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_core1", {core_a1, core_b1, core_c1, core_d1}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid4 = 1'b0; in_valid1 = 1'b0;
        out_ready4 = 1'b1; out_ready1 = 1'b1;

        // Single sample and tie
        send4(32'h0202_0002, 1);
        send4(32'h0000_0202, 1);
        drain4();

        // Backpressure with a second sample offered during DONE
        out_ready4 = 1'b0;
        send4(32'h0201_0302, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b1;
        in_data4  = 32'h0202_0202;
        q4.push_back(model(128'(32'h0202_0202), 4));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready4", in_ready4, 1'b0);
            chk("bp_out_valid4", out_valid4, 1'b1);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_ready4", in_ready4, 1'b1);
        chk("bp_idle_valid4", out_valid4, 1'b0);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("bp_second_busy4", busy4, 1'b1);
        chk("bp_second_core_a4", core_a4, 2'd2);
        drain4();

        // Reset during the second RUN cycle
        accept4(32'h0202_0202, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy4", busy4, 1'b0);
        chk("mid_rst_in_ready4", in_ready4, 1'b1);
        chk("mid_rst_valid4", out_valid4, 1'b0);
        chk("mid_rst_bits4", out_bits4, 4'd0);
        chk("mid_rst_count4", out_count4, 3'd0);
        repeat (6) begin
            @(negedge clk);
            chk("mid_rst_no_valid4", out_valid4, 1'b0);
        end
        send4(32'h0202_0002, 1);
        drain4();

        // Random samples with random backpressure
        rand_rdy = 1;
        repeat (25) send4($urandom, 1);
        rand_rdy = 0;
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        drain4();

        // N_GROUPS = 1
        send1(8'h02);
        send1(8'h01);
        repeat (8) send1(8'($urandom));
        drain1();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
